divergent_scheduler: RTL



---
 rtl/divergent_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/divergent_scheduler.sv
// Per-core block scheduler with per-thread PCs and min-PC reconvergence.
// Issues each instruction to all live threads sitting at the lowest live PC.
module divergent_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [$clog2(THREADS_PER_BLOCK):0] thread_count,
  input  logic decoded_ret,
  input  logic decoded_mem_read_enable,
  input  logic decoded_mem_write_enable,
  input  logic [2:0] fetcher_state,
  input  logic [THREADS_PER_BLOCK-1:0][1:0] lsu_state,
  input  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0] next_pc,
  output logic [PC_BITS-1:0] current_pc,
  output logic [THREADS_PER_BLOCK-1:0] active_mask,
  output logic [2:0] core_state,
  output logic done
);
  localparam int T = THREADS_PER_BLOCK;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t r_state, w_state;
  logic [PC_BITS-1:0] r_pc, w_pc;
  logic [T-1:0] r_mask, w_mask;
  logic r_done, w_done;
  logic [T-1:0][PC_BITS-1:0] r_tpc, w_tpc;
  logic [T-1:0] r_tdone, w_tdone;

  logic [T-1:0] w_en;
  logic [T-1:0][PC_BITS-1:0] w_new_pc;
  logic [T-1:0] w_new_done;
  logic [PC_BITS-1:0] w_min;
  logic w_busy;
  logic w_unused_mem;

  assign w_unused_mem = decoded_mem_read_enable ^ decoded_mem_write_enable;

  always_comb begin
    w_en = '0;
    w_new_pc = r_tpc;
    w_new_done = r_tdone;
    w_min = '1;
    w_busy = 1'b0;
    for (int i = 0; i < T; i++) begin
      w_en[i] = int'(thread_count) > i;
      if (r_mask[i]) w_new_pc[i] = next_pc[i];
      w_new_done[i] = r_tdone[i] | (r_mask[i] & decoded_ret);
      if (r_mask[i] && (lsu_state[i] == 2'b01 || lsu_state[i] == 2'b10))
        w_busy = 1'b1;
    end
    // lowest PC among threads that are still live after this update
    for (int i = 0; i < T; i++) begin
      if (!w_new_done[i] && w_new_pc[i] < w_min) w_min = w_new_pc[i];
    end
  end

  always_comb begin
    w_state = r_state;
    w_pc = r_pc;
    w_mask = r_mask;
    w_done = r_done;
    w_tpc = r_tpc;
    w_tdone = r_tdone;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_tpc = '0;
          w_tdone = ~w_en;
          w_pc = '0;
          if (w_en == '0) begin
            w_mask = '0;
            w_done = 1'b1;
            w_state = S_DONE;
          end else begin
            w_mask = w_en;
            w_state = S_FETCH;
          end
        end
      end
      S_FETCH: if (fetcher_state == 3'b010) w_state = S_DECODE;
      S_DECODE: w_state = S_REQUEST;
      S_REQUEST: w_state = S_WAIT;
      S_WAIT: if (!w_busy) w_state = S_EXECUTE;
      S_EXECUTE: w_state = S_UPDATE;
      S_UPDATE: begin
        w_tpc = w_new_pc;
        w_tdone = w_new_done;
        if (&w_new_done) begin
          w_done = 1'b1;
          w_mask = '0;
          w_state = S_DONE;
        end else begin
          w_pc = w_min;
          for (int i = 0; i < T; i++)
            w_mask[i] = !w_new_done[i] && (w_new_pc[i] == w_min);
          w_state = S_FETCH;
        end
      end
      S_DONE: begin
        if (!start) begin
          w_done = 1'b0;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc <= '0;
      r_mask <= '0;
      r_done <= 1'b0;
      r_tpc <= '0;
      r_tdone <= '1;
    end else begin
      r_state <= w_state;
      r_pc <= w_pc;
      r_mask <= w_mask;
      r_done <= w_done;
      r_tpc <= w_tpc;
      r_tdone <= w_tdone;
    end
  end

  assign current_pc = r_pc;
  assign active_mask = r_mask;
  assign core_state = r_state;
  assign done = r_done;
endmodule
